mem_access_stage: RTL and testbench

- Memory stage of the 5-stage pipeline; the consuming end of the execute-to-memory handshake driven by the execute-stage ALU.
- Accepts alu_result, rs2_data, opcode, funct3 and rd from execute, and issues load/store transactions on the data-memory bus with a req/ack handshake.
- Aligns and extends load data and presents one registered result to writeback with valid/ready.
- One instruction in flight; back-pressures execute via ex_ready.

---
 rtl/mem_access_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory stage: accepts one execute payload at a time, runs the data-memory req/ack
// transaction for loads/stores, and holds a single registered writeback result.
module mem_access_stage #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [4:0]      ex_rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_result,
   output logic [4:0]      wb_rd,
   output logic            wb_we,
   output logic            wb_fault
);

   // state  | meaning
   // IDLE   | can accept a new payload (subject to the writeback slot)
   // ACCESS | dmem_req held high, waiting for ack or timeout
   // RESP   | memory result loaded, waiting for writeback to take it

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_REG_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG_REG = 7'b0110011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;

   localparam int          CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TC_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state, state_nxt;
   logic            accept, is_load, is_store, misaligned, writes_rd;
   logic            ack_hit, expire, wb_xfer, wb_load, mem_start;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] addr_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [XLEN-1:0] load_data, wdata_c, res_nxt;
   logic [3:0]      be_c;
   logic [4:0]      rd_nxt;
   logic            we_nxt, fault_nxt;

   assign ex_ready  = !rst && (state == IDLE) && (!wb_valid || wb_ready);
   assign accept    = ex_valid && ex_ready;
   assign is_load   = (ex_opcode == OP_LOAD);
   assign is_store  = (ex_opcode == OP_STORE);
   assign writes_rd = (ex_opcode == OP_REG_REG) || (ex_opcode == OP_REG_IMM) ||
                      (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
   assign ack_hit   = dmem_req && dmem_ack;
   assign expire    = (TIMEOUT_CYCLES != 0) && (count == TC_LAST) && !ack_hit;
   assign wb_xfer   = wb_valid && wb_ready;

   // Width code 11 has no legal access; a store with funct3 110 is rejected as well.
   always_comb begin
      misaligned = 1'b0;
      case (ex_funct3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = ex_alu_result[0];
         2'b10:   misaligned = |ex_alu_result[1:0];
         default: misaligned = 1'b1;
      endcase
      if (is_store && (ex_funct3 == 3'b110))
         misaligned = 1'b1;
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = ex_rs2_data;
      case (ex_funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << ex_alu_result[1:0];
            wdata_c = {(XLEN/8){ex_rs2_data[7:0]}};
         end
         2'b01: begin
            be_c    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_c = {(XLEN/16){ex_rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane_b    = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h    = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      case (f3_q)
         3'b000:  load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_b};
         3'b001:  load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_h};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wb_load   = 1'b0;
      mem_start = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if ((is_load || is_store) && !misaligned) begin
                  mem_start = 1'b1;
                  state_nxt = ACCESS;
               end else begin
                  wb_load = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (ack_hit || expire) begin
               wb_load   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (wb_xfer) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      res_nxt   = ex_alu_result;
      rd_nxt    = ex_rd;
      we_nxt    = 1'b0;
      fault_nxt = 1'b0;
      if (state == ACCESS) begin
         res_nxt = addr_q;
         rd_nxt  = rd_q;
         if (ack_hit) begin
            if (!dmem_we) res_nxt = load_data;
            we_nxt = !dmem_we && (|rd_q);
         end else begin
            fault_nxt = 1'b1;
         end
      end else if (is_load || is_store) begin
         fault_nxt = 1'b1;
      end else begin
         we_nxt = writes_rd && (|ex_rd);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= 4'b0000;
         addr_q     <= '0;
         f3_q       <= 3'b000;
         rd_q       <= 5'd0;
         count      <= '0;
         wb_valid   <= 1'b0;
         wb_result  <= '0;
         wb_rd      <= 5'd0;
         wb_we      <= 1'b0;
         wb_fault   <= 1'b0;
      end else begin
         if (mem_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
            dmem_wdata <= wdata_c;
            dmem_be    <= be_c;
            addr_q     <= ex_alu_result;
            f3_q       <= ex_funct3;
            rd_q       <= ex_rd;
            count      <= '0;
         end else if (state == ACCESS) begin
            if (ack_hit || expire) dmem_req <= 1'b0;
            else                   count    <= count + 1'b1;
         end
         if (wb_load) begin
            wb_valid  <= 1'b1;
            wb_result <= res_nxt;
            wb_rd     <= rd_nxt;
            wb_we     <= we_nxt;
            wb_fault  <= fault_nxt;
         end else if (wb_xfer) begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes model results at accept,
// a memory responder checks bus requests, and a monitor checks writeback transfers.
module tb_mem_access_stage;
   localparam int TO = 16;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_REG_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG_REG = 7'b0110011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
      logic        fault;
      logic        chk_res;
      int          cyc;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      int          len;
   } mem_exp_t;

   logic        clk, rst, ex_valid, ex_ready;
   logic [31:0] ex_alu_result, ex_rs2_data;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_ready, wb_we, wb_fault;
   logic [31:0] wb_result;
   logic [4:0]  wb_rd;

   int n_cmp = 0, n_bad = 0, cyc = 0, rdy_mode = 0;
   bit resp_en = 1, late_ack = 0;
   wb_exp_t  eq[$];
   mem_exp_t mq[$];

   mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_result(wb_result), .wb_rd(wb_rd), .wb_we(wb_we),
      .wb_fault(wb_fault)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: result/bus expectations from the ISA load/store rules.
   task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                        input int delay, output wb_exp_t w, output bit mem, output mem_exp_t m);
      int size, off;
      logic [31:0] raw, v;
      w.res = a; w.rd = rd; w.we = 1'b0; w.fault = 1'b0; w.chk_res = 1'b1; w.cyc = 0;
      mem = 0;
      m.we = 1'b0; m.addr = 0; m.be = 0; m.wdata = 0; m.rdata = rdata; m.delay = delay; m.len = 0;
      if (op == OP_LOAD || op == OP_STORE) begin
         size = 1 << f3[1:0];
         off  = int'(a % 4);
         if (f3[1:0] == 2'b11 || (op == OP_STORE && f3 == 3'b110) || (a % size) != 0) begin
            w.fault = 1'b1;
         end else begin
            mem    = 1;
            m.we   = (op == OP_STORE);
            m.addr = a - off;
            m.be   = 4'((1 << size) - 1) << off;
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
            m.len  = (delay < TO) ? delay + 1 : TO;
            w.cyc  = m.len;
            if (delay >= TO) begin
               w.fault = 1'b1;
               w.chk_res = 1'b0;
            end else if (op == OP_LOAD) begin
               raw = rdata >> (8 * off);
               if (size == 1) begin
                  v = raw & 32'hFF;
                  if (!f3[2] && v >= 32'd128) v = v - 32'd256;
               end else if (size == 2) begin
                  v = raw & 32'hFFFF;
                  if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
               end else begin
                  v = rdata;
               end
               w.res = v;
               w.we  = (rd != 0);
            end
         end
      end else begin
         w.we = (op == OP_REG_REG || op == OP_REG_IMM || op == OP_JAL || op == OP_JALR) && rd != 0;
      end
   endtask

   task automatic drive_rdy();
      case (rdy_mode)
         0:       wb_ready = 1'b1;
         1:       wb_ready = ($urandom_range(0, 3) != 0);
         default: wb_ready = 1'b0;
      endcase
   endtask

   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                       input int delay, output int waited);
      wb_exp_t w;
      mem_exp_t m;
      bit mem;
      waited = 0;
      @(negedge clk);
      ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3; ex_alu_result = a;
      ex_rs2_data = rs2; ex_rd = rd;
      drive_rdy();
      #1;
      while (!ex_ready && waited < 300) begin
         @(negedge clk);
         drive_rdy();
         #1;
         waited++;
      end
      if (!ex_ready) begin
         chk("accept_wait", 32'(ex_ready), 32'd1);
         ex_valid = 1'b0;
      end else begin
         model(op, f3, a, rs2, rd, rdata, delay, w, mem, m);
         w.cyc += cyc + 1;
         eq.push_back(w);
         if (mem) mq.push_back(m);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      ex_valid = 1'b0;
      ex_opcode = 7'($urandom);
      ex_alu_result = $urandom;
      drive_rdy();
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 0;
      while ((eq.size() != 0 || dmem_req) && n < 200) begin
         @(negedge clk);
         ex_valid = 1'b0;
         drive_rdy();
         #1;
         n++;
      end
      @(negedge clk);
      ex_valid = 1'b0;
      #3;
      chk("drain_empty", 32'(eq.size()), 32'd0);
   endtask

   // Memory responder
   mem_exp_t cur_m;
   int  k = 0;
   bit  active = 0;
   initial begin
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         dmem_ack = 1'b0;
         dmem_rdata = $urandom;
         if (!resp_en) begin
            dmem_ack = late_ack;
         end else begin
            if (!active && dmem_req) begin
               active = 1;
               k = 0;
               if (mq.size() == 0) begin
                  chk("unexpected_req", 32'd1, 32'd0);
                  cur_m.delay = 0;
                  cur_m.len = 1;
                  cur_m.rdata = 0;
               end else begin
                  cur_m = mq.pop_front();
                  chk("req_we", 32'(dmem_we), 32'(cur_m.we));
                  chk("req_addr", dmem_addr, cur_m.addr);
                  chk("req_be", 32'(dmem_be), 32'(cur_m.be));
                  if (cur_m.we) chk("req_wdata", dmem_wdata, cur_m.wdata);
               end
            end else if (active && !dmem_req) begin
               active = 0;
               chk("req_len", 32'(k), 32'(cur_m.len));
            end
            if (active) begin
               if (k == cur_m.delay) begin
                  dmem_ack = 1'b1;
                  dmem_rdata = cur_m.rdata;
               end
               k++;
            end
         end
      end
   end

   // Writeback monitor
   bit cur_seen = 0;
   int seen_cyc = 0;
   initial forever begin
      wb_exp_t e;
      @(negedge clk);
      #2;
      if (rst) begin
         cur_seen = 0;
      end else begin
         if (wb_valid && !cur_seen) begin
            cur_seen = 1;
            seen_cyc = cyc;
         end
         if (wb_valid && wb_ready) begin
            cur_seen = 0;
            if (eq.size() == 0) begin
               chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
               e = eq.pop_front();
               chk("wb_rd", 32'(wb_rd), 32'(e.rd));
               chk("wb_we", 32'(wb_we), 32'(e.we));
               chk("wb_fault", 32'(wb_fault), 32'(e.fault));
               if (e.chk_res) chk("wb_result", wb_result, e.res);
               chk("wb_latency", 32'(seen_cyc), 32'(e.cyc));
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int w, nr, nq;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [4:0]  rd;
      int          dly, r;
      logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  st_f3[6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
      logic [6:0]  misc_op[3] = '{OP_JAL, OP_JALR, OP_BRANCH};

      rst = 1; ex_valid = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_opcode = 0;
      ex_funct3 = 0; ex_rd = 0; wb_ready = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_result", wb_result, 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd0);
      chk("rst_dmem_be", 32'(dmem_be), 32'd0);
      @(negedge clk);
      rst = 0;
      wb_ready = 1;
      #1;
      chk("ex_ready_after_rst", 32'(ex_ready), 32'd1);

      send(OP_REG_REG, 3'b000, 32'h0000_0042, 32'h1111, 5'd5, 0, 0, w);
      send(OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 1, w);
      send(OP_LOAD, 3'b000, 32'h0000_0203, 0, 5'd10, 32'h80FF_FF7F, 0, w);
      send(OP_LOAD, 3'b100, 32'h0000_0203, 0, 5'd11, 32'h80FF_FF7F, 0, w);
      send(OP_LOAD, 3'b001, 32'h0000_0202, 0, 5'd12, 32'h80FF_FF7F, 0, w);
      send(OP_LOAD, 3'b010, 32'h0000_0102, 0, 5'd13, 0, 0, w);
      send(OP_STORE, 3'b001, 32'h0000_0101, 32'h5555, 5'd0, 0, 0, w);
      send(OP_STORE, 3'b000, 32'h0000_0305, 32'h0000_00A5, 5'd0, 0, 2, w);
      send(OP_BRANCH, 3'b000, 32'h0000_0777, 0, 5'd4, 0, 0, w);
      send(OP_JAL, 3'b000, 32'h0000_0888, 0, 5'd0, 0, 0, w);
      send(7'b1111111, 3'b000, 32'h0000_0999, 0, 5'd3, 0, 0, w);
      drain();

      // Withheld ack: bus must time out with the stage blocked throughout
      send(OP_LOAD, 3'b010, 32'h0000_0400, 0, 5'd9, 32'h1234_5678, 99, w);
      nr = 0; nq = 0;
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         ex_valid = 1'b0;
         drive_rdy();
         #1;
         if (ex_ready) nr++;
         if (!dmem_req) nq++;
      end
      chk("timeout_ex_ready_low", 32'(nr), 32'd0);
      chk("timeout_req_high", 32'(nq), 32'd0);
      @(negedge clk);
      #1;
      chk("timeout_req_drop", 32'(dmem_req), 32'd0);
      drain();

      // Writeback stall, then same-cycle transfer and accept
      rdy_mode = 2;
      send(OP_REG_REG, 3'b000, 32'h0000_1234, 0, 5'd7, 0, 0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ex_valid = 1'b0;
         drive_rdy();
         #1;
         chk("stall_wb_valid", 32'(wb_valid), 32'd1);
         chk("stall_wb_result", wb_result, 32'h0000_1234);
         chk("stall_ex_ready", 32'(ex_ready), 32'd0);
      end
      rdy_mode = 0;
      send(OP_REG_IMM, 3'b000, 32'h0000_0055, 0, 5'd8, 0, 0, w);
      chk("same_cycle_accept", 32'(w), 32'd0);
      drain();

      rdy_mode = 1;
      for (int t = 0; t < 250; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else begin
            r = $urandom_range(0, 9);
            f3 = 3'($urandom);
            if (r <= 2) begin
               op = OP_LOAD;
               f3 = ld_f3[$urandom_range(0, 4)];
            end else if (r <= 5) begin
               op = OP_STORE;
               f3 = st_f3[$urandom_range(0, 5)];
            end else if (r == 6) op = OP_REG_REG;
            else if (r == 7) op = OP_REG_IMM;
            else if (r == 8) op = misc_op[$urandom_range(0, 2)];
            else op = 7'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r = $urandom_range(0, 11);
            if (r == 0) dly = 20;
            else if (r == 1) dly = TO - 1;
            else dly = $urandom_range(0, 4);
            send(op, f3, a, $urandom, rd, $urandom, dly, w);
         end
      end
      drain();

      // Asynchronous reset in the middle of a bus transaction
      resp_en = 0;
      late_ack = 1'b0;
      @(negedge clk);
      ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_funct3 = 3'b010;
      ex_alu_result = 32'h0000_0300; ex_rd = 5'd3; wb_ready = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      chk("rst_mid_req_before", 32'(dmem_req), 32'd1);
      #1;
      rst = 1'b1;
      late_ack = 1'b1;
      #1;
      chk("rst_mid_req_drop", 32'(dmem_req), 32'd0);
      chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("late_ack_req", 32'(dmem_req), 32'd0);
         chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
      end
      chk("post_rst_ex_ready", 32'(ex_ready), 32'd1);
      late_ack = 1'b0;

      chk("final_wb_queue", 32'(eq.size()), 32'd0);
      chk("final_mem_queue", 32'(mq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
